// File: rtl/regfile_wr_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wr_arbiter
//
// Shares the register file's single write port among NUM_REQ writeback
// requesters (ALU, load unit, CSR, ...). A round-robin arbiter picks one valid
// requester per cycle and accepts it through a valid/ready handshake. The
// accepted write is registered onto we/waddr/wdata, so it reaches the register
// file one cycle after the handshake.
//
// A 32-entry pending-write scoreboard (busy) is kept alongside. Decode claims a
// destination register when it issues. The bit clears on the edge where the
// matching write is registered, which is the same edge on which we rises.
// Decode reads in that cycle get the value through the register file's
// write-to-read bypass.
//
// Ports
//   clk          in   rising-edge clock for all state
//   rst          in   asynchronous reset, active-low (0 = reset)
//   req_valid    in   [NUM_REQ]         requester i has a write pending
//   req_addr     in   [NUM_REQ*ADDR_W]  requester i destination, slice i*ADDR_W
//   req_data     in   [NUM_REQ*DATA_W]  requester i data, slice i*DATA_W
//   req_ready    out  [NUM_REQ]         one-hot grant
//   wb_stall     in   accept nothing this cycle
//   claim_valid  in   decode claims claim_addr as an outstanding destination
//   claim_addr   in   [ADDR_W]          register being claimed
//   we           out  register file write enable
//   waddr        out  [ADDR_W]          register file write address
//   wdata        out  [DATA_W]          register file write data
//   busy         out  [32]              pending-write scoreboard, bit 0 tied 0
// -----------------------------------------------------------------------------
module regfile_wr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       wb_stall,
    input  logic                       claim_valid,
    input  logic [ADDR_W-1:0]          claim_addr,
    output logic                       we,
    output logic [ADDR_W-1:0]          waddr,
    output logic [DATA_W-1:0]          wdata,
    output logic [31:0]                busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   rr_ptr_nxt;
    logic [PTR_W-1:0]   grant_idx;
    logic               grant_found;
    logic [NUM_REQ-1:0] grant_oh;
    logic               hs;
    logic [ADDR_W-1:0]  grant_addr;
    logic [DATA_W-1:0]  grant_data;
    logic [31:0]        busy_nxt;

    // Round-robin search. The first pass looks at indices at or above rr_ptr.
    // The second pass covers the wrap-around and only wins when the first pass
    // found nothing, which gives the (rr_ptr + k) mod NUM_REQ priority order.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_found && req_valid[i] && (PTR_W'(i) >= rr_ptr)) begin
                grant_found = 1'b1;
                grant_idx   = PTR_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_found && req_valid[i]) begin
                grant_found = 1'b1;
                grant_idx   = PTR_W'(i);
            end
        end
    end

    always_comb begin
        grant_oh = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_oh[i] = grant_found && (grant_idx == PTR_W'(i));
        end
    end

    // Ready is gated by reset as well as stall. This keeps a requester from
    // seeing a handshake while the registers are held in reset.
    assign req_ready = (rst && !wb_stall) ? grant_oh : '0;
    assign hs        = |(req_valid & req_ready);

    // One-hot mux of the granted requester's address and data.
    always_comb begin
        grant_addr = '0;
        grant_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_oh[i]) begin
                grant_addr = req_addr[i*ADDR_W +: ADDR_W];
                grant_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign rr_ptr_nxt = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    // The clear is applied before the set, so a claim and a retiring write to
    // the same register in one cycle leave the bit set. That case is a new
    // instruction claiming a register whose older write is just retiring.
    always_comb begin
        busy_nxt = busy;
        if (hs && (grant_addr != '0)) begin
            busy_nxt[grant_addr] = 1'b0;
        end
        if (claim_valid && (claim_addr != '0)) begin
            busy_nxt[claim_addr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
            we     <= 1'b0;
            waddr  <= '0;
            wdata  <= '0;
            busy   <= '0;
        end else begin
            busy <= busy_nxt;
            if (hs) begin
                rr_ptr <= rr_ptr_nxt;
                // x0 writes complete the handshake but never reach the file.
                we     <= (grant_addr != '0);
                waddr  <= grant_addr;
                wdata  <= grant_data;
            end else begin
                we     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
module tb_regfile_wr_arbiter;

    localparam int NR = 3;
    localparam int AW = 5;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]   req_ready;
    logic            wb_stall;
    logic            claim_valid;
    logic [AW-1:0]   claim_addr;
    logic            we;
    logic [AW-1:0]   waddr;
    logic [DW-1:0]   wdata;
    logic [31:0]     busy;

    regfile_wr_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .wb_stall    (wb_stall),
        .claim_valid (claim_valid),
        .claim_addr  (claim_addr),
        .we          (we),
        .waddr       (waddr),
        .wdata       (wdata),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: the next requester to favour, the set of
    // registers with outstanding writes, and what the write port shows.
    int          m_ptr;
    bit          m_busy [32];
    bit          m_we;
    int          m_waddr;
    longint      m_wdata;
    logic [NR-1:0] seen_ready;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_busy_vec();
        logic [31:0] v;
        v = '0;
        for (int r = 0; r < 32; r++) v[r] = m_busy[r];
        return v;
    endfunction

    task automatic model_reset();
        m_ptr   = 0;
        m_we    = 0;
        m_waddr = 0;
        m_wdata = 0;
        for (int r = 0; r < 32; r++) m_busy[r] = 0;
    endtask

    // Returns the requester that wins this cycle, -1 for none.
    function automatic int model_pick();
        if (!rst || wb_stall) return -1;
        for (int off = 0; off < NR; off++) begin
            int j;
            j = (m_ptr + off) % NR;
            if (req_valid[j]) return j;
        end
        return -1;
    endfunction

    // Entered at a falling edge with inputs already driven; returns at the
    // next falling edge.
    task automatic cycle();
        int g;
        int a;
        logic [NR-1:0] exp_ready;
        #1;
        g = model_pick();
        exp_ready = (g >= 0) ? NR'(1 << g) : '0;
        seen_ready = req_ready;
        chk("req_ready", req_ready, exp_ready);
        @(posedge clk);
        if (rst) begin
            if (g >= 0) begin
                a       = int'(req_addr[g*AW +: AW]);
                m_ptr   = (g + 1) % NR;
                m_we    = (a != 0);
                m_waddr = a;
                m_wdata = longint'(req_data[g*DW +: DW]);
                if (a != 0) m_busy[a] = 0;
            end else begin
                m_we = 0;
            end
            if (claim_valid && claim_addr != 0) m_busy[claim_addr] = 1;
        end
        #1;
        chk("we", we, m_we);
        chk("waddr", waddr, m_waddr);
        chk("wdata", wdata, m_wdata);
        chk("busy", busy, model_busy_vec());
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]          = v;
        req_addr[i*AW +: AW]  = a;
        req_data[i*DW +: DW]  = d;
    endtask

    initial begin
        rst         = 1'b0;
        req_valid   = '1;
        req_addr    = '0;
        req_data    = '0;
        wb_stall    = 1'b0;
        claim_valid = 1'b0;
        claim_addr  = '0;
        model_reset();
        set_req(0, 1'b1, 5'd1, 32'hA0A0_0001);
        set_req(1, 1'b1, 5'd2, 32'hB0B0_0002);
        set_req(2, 1'b1, 5'd3, 32'hC0C0_0003);

        // Reset holds ready low even with everyone requesting.
        @(negedge clk);
        cycle();
        chk("rst_ready", seen_ready, 3'b000);
        chk("rst_we", we, 1'b0);
        chk("rst_busy", busy, 32'h0);

        // Round-robin over three held requests: 0,1,2,0.
        rst = 1'b1;
        cycle();
        chk("rr_g0", seen_ready, 3'b001);
        chk("rr_w0", {we, waddr}, {1'b1, 5'd1});
        cycle();
        chk("rr_g1", seen_ready, 3'b010);
        chk("rr_w1", {we, waddr, wdata}, {1'b1, 5'd2, 32'hB0B0_0002});
        cycle();
        chk("rr_g2", seen_ready, 3'b100);
        chk("rr_w2", {we, waddr}, {1'b1, 5'd3});
        cycle();
        chk("rr_g3", seen_ready, 3'b001);

        // Stall blocks acceptance; the write lands the cycle after release.
        req_valid = '0;
        set_req(1, 1'b1, 5'd5, 32'hDEAD_BEEF);
        wb_stall = 1'b1;
        cycle();
        chk("stall_rdy0", seen_ready, 3'b000);
        chk("stall_we0", we, 1'b0);
        cycle();
        chk("stall_rdy1", seen_ready, 3'b000);
        wb_stall = 1'b0;
        cycle();
        chk("stall_rel", seen_ready, 3'b010);
        chk("stall_wr", {we, waddr, wdata}, {1'b1, 5'd5, 32'hDEAD_BEEF});

        // x0 write is accepted and dropped; an x0 claim does nothing.
        req_valid = '0;
        set_req(0, 1'b1, 5'd0, 32'h0000_1234);
        claim_valid = 1'b1;
        claim_addr  = 5'd0;
        cycle();
        chk("x0_ready", seen_ready, 3'b001);
        chk("x0_we", we, 1'b0);
        chk("x0_busy", busy, 32'h0);

        // Scoreboard: claim, claim+retire same cycle, plain retire.
        req_valid   = '0;
        claim_addr  = 5'd7;
        cycle();
        chk("sb_claim", busy[7], 1'b1);
        set_req(0, 1'b1, 5'd7, 32'h7777_0001);
        cycle();
        chk("sb_both", {busy[7], we}, 2'b11);
        claim_valid = 1'b0;
        set_req(0, 1'b1, 5'd7, 32'h7777_0002);
        cycle();
        chk("sb_clear", {busy[7], we}, 2'b01);

        // Randomized phase: requesters hold addr/data until accepted.
        req_valid = '0;
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NR; i++) begin
                if (!req_valid[i] && ($urandom_range(0, 1) == 1)) begin
                    set_req(i, 1'b1, AW'($urandom_range(0, 31)), $urandom);
                end
            end
            wb_stall    = ($urandom_range(0, 4) == 0);
            claim_valid = ($urandom_range(0, 2) != 0);
            claim_addr  = AW'($urandom_range(0, 31));
            cycle();
            req_valid = req_valid & ~seen_ready;
        end

        // Async reset between a handshake edge and the next edge.
        wb_stall    = 1'b0;
        req_valid   = '0;
        claim_valid = 1'b1;
        claim_addr  = 5'd12;
        set_req(1, 1'b1, 5'd9, 32'h0909_0909);
        cycle();
        chk("ar_pre_we", we, 1'b1);
        chk("ar_pre_busy", busy[12], 1'b1);
        claim_valid = 1'b0;
        rst = 1'b0;
        model_reset();
        #1;
        chk("ar_we", we, 1'b0);
        chk("ar_busy", busy, 32'h0);
        chk("ar_wr", {waddr, wdata}, {5'd0, 32'h0});
        req_valid = '1;
        @(negedge clk);
        cycle();
        chk("ar_hold_rdy", seen_ready, 3'b000);
        rst = 1'b1;
        cycle();
        chk("ar_first", seen_ready, 3'b001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls on the clock.
    initial begin
        #200000;
        $display("FAIL timeout: simulation ran past its time limit");
        $fatal(1, "timeout");
    end

endmodule
